// File: rtl/fst_run_ctrl_if.sv
// fst_run_ctrl_if: request, core-side and status signals of the fst run/step/halt sequencer.
// slave is the sequencer side; master is the board/core side that drives requests.
interface fst_run_ctrl_if #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned CNT_W = 32
);
  logic             run_req;
  logic             step_req;
  logic             stop_req;
  logic             is_halt;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_valid;
  logic             core_reset;
  logic             core_en;
  logic             halting;
  logic [2:0]       state_out;
  logic [CNT_W-1:0] cycle_cnt;
  logic             step_done;
  logic             bp_hit;

  modport slave (
    input  run_req, step_req, stop_req, is_halt, pc, bp_addr, bp_valid,
    output core_reset, core_en, halting, state_out, cycle_cnt, step_done, bp_hit
  );

  modport master (
    output run_req, step_req, stop_req, is_halt, pc, bp_addr, bp_valid,
    input  core_reset, core_en, halting, state_out, cycle_cnt, step_done, bp_hit
  );
endinterface

// File: rtl/fst_run_ctrl.sv
// fst_run_ctrl: run/step/halt sequencer; owns core reset, per-cycle core enable and cycle count.
// The PC breakpoint is built only when FST_RUN_CTRL_BP_EN is defined.
module fst_run_ctrl #(
  parameter int unsigned PC_W       = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RST_CYCLES = 4
) (
  input logic           clk,
  input logic           reset_n,
  fst_run_ctrl_if.slave io_ctrl
);

  localparam int unsigned       INIT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StInit = 3'd0,
    StIdle = 3'd1,
    StRun  = 3'd2,
    StStep = 3'd3,
    StHalt = 3'd4
  } state_e;

  state_e            r_state;
  logic [INIT_W-1:0] r_init_cnt;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic              r_halting;
  logic              r_step_done;
  logic              r_bp_hit;
  logic              r_run_prev;
  logic              r_step_prev;
  logic              r_stop_prev;

  logic w_run_edge;
  logic w_step_edge;
  logic w_stop_edge;
  logic w_bp_match;
  logic w_core_en;
  logic w_cnt_sat;

  // History resets high so a request level held through reset never acts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_run_prev  <= 1'b1;
      r_step_prev <= 1'b1;
      r_stop_prev <= 1'b1;
    end else begin
      r_run_prev  <= io_ctrl.run_req;
      r_step_prev <= io_ctrl.step_req;
      r_stop_prev <= io_ctrl.stop_req;
    end
  end

  assign w_run_edge  = io_ctrl.run_req  & ~r_run_prev;
  assign w_step_edge = io_ctrl.step_req & ~r_step_prev;
  assign w_stop_edge = io_ctrl.stop_req & ~r_stop_prev;

`ifdef FST_RUN_CTRL_BP_EN
  logic [PC_W-1:0] w_pc;
  logic [PC_W-1:0] w_bp_addr;
  logic            r_bp_skip;

  assign w_pc      = io_ctrl.pc;
  assign w_bp_addr = io_ctrl.bp_addr;

  // Masks the match on the first RUN cycle so resuming at bp_addr executes that instruction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bp_skip <= 1'b0;
    end else if (r_state == StIdle && w_run_edge) begin
      r_bp_skip <= 1'b1;
    end else if (r_state == StRun) begin
      r_bp_skip <= 1'b0;
    end
  end

  assign w_bp_match = (r_state == StRun) && io_ctrl.bp_valid && (w_pc == w_bp_addr) &&
                      !r_bp_skip;
`else
  logic [PC_W:0] w_unused_bp;
  assign w_unused_bp = {io_ctrl.bp_valid, io_ctrl.pc ^ io_ctrl.bp_addr};
  assign w_bp_match  = 1'b0;
`endif

  assign w_core_en = (r_state == StStep) || ((r_state == StRun) && !w_bp_match);
  assign w_cnt_sat = &r_cycle_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StInit;
      r_init_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_halting   <= 1'b0;
      r_step_done <= 1'b0;
      r_bp_hit    <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      r_bp_hit    <= 1'b0;
      if (w_core_en && !w_cnt_sat) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      unique case (r_state)
        StInit: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state    <= StIdle;
            r_init_cnt <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + INIT_W'(1);
          end
        end
        StIdle: begin
          if (w_run_edge) begin
            r_state <= StRun;
          end else if (w_step_edge) begin
            r_state <= StStep;
          end
        end
        StRun: begin
          // is_halt only counts when the core actually executed this cycle.
          if (io_ctrl.is_halt && w_core_en) begin
            r_state   <= StHalt;
            r_halting <= 1'b1;
          end else if (w_bp_match) begin
            r_state  <= StIdle;
            r_bp_hit <= 1'b1;
          end else if (w_stop_edge) begin
            r_state <= StIdle;
          end
        end
        StStep: begin
          if (io_ctrl.is_halt) begin
            r_state   <= StHalt;
            r_halting <= 1'b1;
          end else begin
            r_state     <= StIdle;
            r_step_done <= 1'b1;
          end
        end
        StHalt: begin
          if (w_run_edge) begin
            r_state     <= StInit;
            r_init_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_halting   <= 1'b0;
          end
        end
        default: begin
          r_state <= StInit;
        end
      endcase
    end
  end

  assign io_ctrl.core_reset = (r_state == StInit);
  assign io_ctrl.core_en    = w_core_en;
  assign io_ctrl.halting    = r_halting;
  assign io_ctrl.state_out  = r_state;
  assign io_ctrl.cycle_cnt  = r_cycle_cnt;
  assign io_ctrl.step_done  = r_step_done;
  assign io_ctrl.bp_hit     = r_bp_hit;

endmodule
